// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider producing quotient and remainder together.
// Handles DIV/DIVU/REM/REMU and their 32-bit word forms, one quotient bit per clock.
module seq_divider #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [XLEN-1:0]   A,
  input  logic [XLEN-1:0]   B,
  input  logic              is_signed,
  input  logic              is_word,
  output logic              ok,
  output logic              busy,
  output logic [2*XLEN-1:0] result
);

  localparam int               CNT_W  = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_X = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(WLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] x, input logic sgn);
    return sgn ? {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]}
               : {{(XLEN-WLEN){1'b0}}, x[WLEN-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] x, input logic word);
    return word ? word_ext(x, 1'b1) : x;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             word_q, word_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [2*XLEN-1:0] result_q, result_d;

  // Operand preparation, meaningful only at the accept edge.
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
  logic            a_neg, b_neg, div_zero, overflow;

  always_comb begin
    a_ext    = is_word ? word_ext(A, is_signed) : A;
    b_ext    = is_word ? word_ext(B, is_signed) : B;
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    min_neg  = is_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                       : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    overflow = is_signed && (a_ext == min_neg) && (b_ext == '1);
  end

  // One restoring step: shift in the next dividend bit, trial-subtract, keep on no borrow.
  logic [XLEN:0]   partial, trial;
  logic            take;
  logic [XLEN-1:0] rem_step, quo_step, q_fin, r_fin;

  always_comb begin
    partial  = {rem_q, quo_q[XLEN-1]};
    trial    = partial - {1'b0, dvs_q};
    take     = ~trial[XLEN];
    rem_step = take ? trial[XLEN-1:0] : partial[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], take};
    q_fin    = neg_quo_q ? -quo_step : quo_step;
    r_fin    = neg_rem_q ? -rem_step : rem_step;
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    word_d    = word_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          word_d    = is_word;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvs_d     = b_mag;
          rem_d     = '0;
          // Word dividends are left-aligned so the step logic always consumes bit XLEN-1.
          quo_d     = is_word ? (a_mag << (XLEN - WLEN)) : a_mag;
          cnt_d     = '0;
          if (div_zero) begin
            result_d = {word_fix(a_ext, is_word), {XLEN{1'b1}}};
            state_d  = DONE;
          end else if (overflow) begin
            result_d = {{XLEN{1'b0}}, a_ext};
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (word_q ? LAST_W : LAST_X)) begin
          result_d = {word_fix(r_fin, word_q), word_fix(q_fin, word_q)};
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too; it costs nothing here and keeps
  // every flop at a known value after a mid-operation reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      word_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      word_q    <= word_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign ok     = (state_q == DONE);
  assign busy   = (state_q == CALC);
  assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues hand-computed results,
// an independent monitor checks them whenever ok pulses.
module tb_seq_divider;

  logic         clk = 1'b0;
  logic         reset, valid, is_signed, is_word;
  logic [63:0]  A, B;
  logic         ok, busy;
  logic [127:0] result;

  seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .A         (A),
    .B         (B),
    .is_signed (is_signed),
    .is_word   (is_word),
    .ok        (ok),
    .busy      (busy),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          busy_n;
    int          issue;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: pops the scoreboard on every ok pulse; also watches result stability while busy.
  initial begin : monitor
    int           busy_run;
    logic         prev_busy;
    logic [127:0] prev_result;
    exp_t         e;
    busy_run  = 0;
    prev_busy = 1'b0;
    prev_result = '0;
    forever begin
      @(negedge clk);
      if (busy && prev_busy) check("result_stable_in_calc", result, prev_result);
      if (busy) busy_run++;
      if (ok) begin
        check("ok_busy_exclusive", {127'd0, busy}, 128'd0);
        if (sb.size() == 0) begin
          check("unexpected_ok", {127'd0, ok}, 128'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_quotient"},  {64'd0, result[63:0]},   {64'd0, e.q});
          check({e.name, "_remainder"}, {64'd0, result[127:64]}, {64'd0, e.r});
          check({e.name, "_latency"},   128'(edge_cnt - e.issue), 128'(e.lat));
          check({e.name, "_busy_cycles"}, 128'(busy_run), 128'(e.busy_n));
        end
        busy_run = 0;
      end else if (!busy) begin
        busy_run = 0;
      end
      prev_busy   = busy;
      prev_result = result;
    end
  end

  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic w, input logic [63:0] q,
                        input logic [63:0] r, input int lat, input int busy_n);
    exp_t e;
    bit   got;
    @(negedge clk);
    e.q = q; e.r = r; e.lat = lat; e.busy_n = busy_n; e.issue = edge_cnt; e.name = name;
    sb.push_back(e);
    A = a; B = b; is_signed = s; is_word = w; valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ok) got = 1'b1;
      else begin
        // Operand changes after the accept edge must have no effect.
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        is_signed = $urandom_range(0, 1) == 1;
        is_word   = $urandom_range(0, 1) == 1;
      end
    end
    valid = 1'b0;
    if (!got) check({name, "_ok_timeout"}, {127'd0, ok}, 128'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset = 1'b1; valid = 1'b0; A = '0; B = '0; is_signed = 1'b0; is_word = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ok",     {127'd0, ok},   128'd0);
    check("reset_busy",   {127'd0, busy}, 128'd0);
    check("reset_result", result,         128'd0);
    reset = 1'b0;

    run_op("divu_100_7",    64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65, 64);
    run_op("div_m7_2",      64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64);
    run_op("divu_by_zero",  64'h1234, 64'd0, 1'b0, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 0);
    run_op("div_overflow",  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
           64'h8000_0000_0000_0000, 64'd0, 1, 0);
    run_op("divw_signed",   64'h0000_0001_FFFF_FFF8, 64'd3, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 33, 32);
    run_op("divuw_msb",     64'h8000_0000, 64'd1, 1'b0, 1'b1,
           64'hFFFF_FFFF_8000_0000, 64'd0, 33, 32);
    run_op("div_m100_m7",   64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0,
           64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65, 64);
    run_op("div_7_m2",      64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 64);
    run_op("divu_max_16",   64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0,
           64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65, 64);
    run_op("divw_zero",     64'h8000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("divw_overflow", 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
           64'hFFFF_FFFF_8000_0000, 64'd0, 1, 0);
    run_op("divuw_max_2",   64'hDEAD_BEEF_FFFF_FFFF, 64'd2, 1'b0, 1'b1,
           64'h0000_0000_7FFF_FFFF, 64'd1, 33, 32);
    run_op("divu_small_big", 64'd5, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 64'd5, 65, 64);
    run_op("divu_max_msb",  64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
           64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 65, 64);

    // Reset in the 10th CALC cycle discards the division.
    @(negedge clk);
    A = 64'd100; B = 64'd7; is_signed = 1'b0; is_word = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_reset_busy_before", {127'd0, busy}, 128'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_busy",   {127'd0, busy}, 128'd0);
    check("mid_reset_ok",     {127'd0, ok},   128'd0);
    check("mid_reset_result", result,         128'd0);
    reset = 1'b0;

    run_op("divu_9_4_after_reset", 64'd9, 64'd4, 1'b0, 1'b0, 64'd2, 64'd1, 65, 64);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
